svn_seg_scan_driver: RTL and testbench
======================================

# svn_seg_scan_driver

Time-multiplexed driver for the 4-digit common-anode seven-segment display. It takes four 4-bit hex digits from the display-select logic (sum, or addends a/b) and converts them to active-low anode and cathode signals. It sits directly downstream of the adder display-select stage and directly drives the board pins. A frame-aligned shadow register prevents tearing when the digit inputs change mid-scan.

## Interface
- REFRESH_DIV, default 100000: clk cycles per digit slot (1 kHz per digit at 100 MHz); legal range ≥2.
- clk  in  1  system clock; all state updates on rising edge.
- clr  in  1  reset, synchronous, active-low (0 = reset).
- dig1  in  4  hex digit for the leftmost display.
- dig2  in  4  hex digit for the second display from the left.
- dig3  in  4  hex digit for the third display from the left.
- dig4  in  4  hex digit for the rightmost display.
- an  out  4  anode enables, active-low; an[3] = leftmost (dig1) … an[0] = rightmost (dig4).
- ca  out  7  cathodes, active-low; ca[0]=a, ca[1]=b … ca[6]=g.

## Operation
- Refresh counter cnt counts 0..REFRESH_DIV-1, then wraps to 0.
- Slot select sel (2 bits) advances 0→1→2→3→0 on the cnt wrap. sel=0 drives dig1, sel=3 drives dig4.
- Shadow register sh[0..3] captures {dig1,dig2,dig3,dig4} under two conditions:
  - at a frame boundary: cnt==REFRESH_DIV-1 and sel==3;
  - on the first cycle after reset (prime flag set in reset, cleared on capture).
- Outputs are registered each cycle:
  - an ← one-cold(sel);
  - ca ← hex7(sh[sel]).
- Outputs are held blank (an=4'b1111, ca=7'b1111111) while the prime flag is set.
- hex7 codes (ca[6:0]):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Input changes between frame boundaries have no visible effect until the next capture.

## Timing
- Reset (clr=0 at a rising edge): cnt=0, sel=0, shadow=0, prime=1, an=4'b1111, ca=7'b1111111.
- First cycle with clr=1 (cycle 1): shadow loads the digit inputs, prime clears, outputs stay blank.
- Cycle 2: an=4'b0111, ca=hex7(dig1 as captured in cycle 1).
- Output lag is one cycle: outputs reflect the sel/cnt state registered in the previous cycle. Each anode is therefore active for exactly REFRESH_DIV consecutive cycles.
- A new frame's digits first appear in the dig1 slot one cycle after the boundary capture.
- Simultaneous boundary capture and input change: the value present at the capturing edge is taken.
- Reset asserted mid-frame: the next edge forces the reset values above. The scan restarts at dig1 after the two-cycle prime sequence.
- The counter is wide enough for REFRESH_DIV-1 (clog2) and never exceeds it; no overflow path exists.

## Configuration
- LEADING_ZERO_BLANK_EN defined:
  - In the shadow values, leading zero digits are blanked, scanning from dig1 rightward and stopping at the first nonzero digit.
  - A blanked digit's slot drives an=4'b1111 and ca=7'b1111111 for its whole slot.
  - The dig4 slot is never blanked, so a value of 0000 shows a single "0".
  - Slot timing is unchanged.
- LEADING_ZERO_BLANK_EN undefined: all four digits are always driven, including leading zeros.

## Test plan
- Reset/prime (REFRESH_DIV=4): hold clr=0 for 3 cycles with dig=1,2,3,4 → an=1111, ca=1111111 throughout reset and cycle 1. Cycle 2: an=0111, ca=1111001.
- Full scan (REFRESH_DIV=4, dig=A,b,C,d) → an sequence 0111,1011,1101,1110, each held 4 cycles. ca values: 0001000, 0000011, 1000110, 0100001. Pattern repeats every 16 cycles.
- Tear-free update: change dig2 from 5 to 6 while the dig1 slot is displayed → dig2 slot still shows 0010010 in that frame. Next frame shows 0000010.
- Mid-frame reset: assert clr=0 during the dig3 slot → an=1111 on the next edge. The scan restarts at the dig1 slot on cycle 2 after release.
- LEADING_ZERO_BLANK_EN, dig=0,0,7,0 → dig1/dig2 slots have an=1111. The dig3 slot shows 1111000, and the dig4 slot shows 1000000.
- LEADING_ZERO_BLANK_EN, dig=0,0,0,0 → only the an=1110 slot is lit, with ca=1000000. Without the macro, all four slots show 1000000.

Source files
------------

// File: rtl/svn_seg_scan_driver.sv
// Four-digit common-anode seven-segment scan driver with a frame-aligned shadow register.
// Optional build macro: LEADING_ZERO_BLANK_EN (blanks leading zero digits; the rightmost digit is always shown).
module svn_seg_scan_driver #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [3:0] dig1,
  input  logic [3:0] dig2,
  input  logic [3:0] dig3,
  input  logic [3:0] dig4,
  output logic [3:0] an,
  output logic [6:0] ca
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sel_q, sel_d;
  logic [3:0]       sh_q [4];
  logic             prime_q;
  logic [3:0]       an_q, an_d;
  logic [6:0]       ca_q, ca_d;

  logic       wrap;
  logic       capture;
  logic [3:0] cur_dig;
  logic [6:0] seg;
  logic       slot_blank;

  assign wrap    = (cnt_q == CNT_LAST);
  assign capture = prime_q | (wrap & (sel_q == 2'd3));
  assign cur_dig = sh_q[sel_q];

  always_comb begin
    seg = 7'b1111111;
    case (cur_dig)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Blank runs from the left and stops at the first nonzero digit; slot 3 is never blanked.
  logic [2:0] lz;
  always_comb begin
    lz = 3'b000;
    lz[0] = (sh_q[0] == 4'h0);
    lz[1] = lz[0] & (sh_q[1] == 4'h0);
    lz[2] = lz[1] & (sh_q[2] == 4'h0);
    slot_blank = (sel_q == 2'd3) ? 1'b0 : lz[sel_q];
  end
`else
  assign slot_blank = 1'b0;
`endif

  always_comb begin
    cnt_d = cnt_q;
    sel_d = sel_q;
    an_d  = 4'b1111;
    ca_d  = 7'b1111111;
    // The scan is frozen while priming so the first dig1 slot gets its full width.
    if (!prime_q) begin
      cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
      if (wrap) sel_d = sel_q + 2'd1;
      if (!slot_blank) begin
        an_d = ~(4'b1000 >> sel_q);
        ca_d = seg;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      cnt_q   <= '0;
      sel_q   <= 2'd0;
      prime_q <= 1'b1;
      an_q    <= 4'b1111;
      ca_q    <= 7'b1111111;
      for (int i = 0; i < 4; i++) sh_q[i] <= 4'h0;
    end else begin
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      an_q    <= an_d;
      ca_q    <= ca_d;
      if (capture) begin
        prime_q <= 1'b0;
        sh_q[0] <= dig1;
        sh_q[1] <= dig2;
        sh_q[2] <= dig3;
        sh_q[3] <= dig4;
      end
    end
  end

  assign an = an_q;
  assign ca = ca_q;

endmodule

// File: tb/tb_svn_seg_scan_driver.sv
// Directed bench for svn_seg_scan_driver with REFRESH_DIV=4; expectations follow LEADING_ZERO_BLANK_EN when defined.
module tb_svn_seg_scan_driver;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] dig1 = 4'h0, dig2 = 4'h0, dig3 = 4'h0, dig4 = 4'h0;
  logic [3:0] an;
  logic [6:0] ca;

  int n_cmp = 0;
  int n_err = 0;

  logic [6:0] seg_tb [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  logic [3:0] an_tb [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

  svn_seg_scan_driver #(.REFRESH_DIV(N)) dut (
    .clk(clk), .clr(clr),
    .dig1(dig1), .dig2(dig2), .dig3(dig3), .dig4(dig4),
    .an(an), .ca(ca)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_digs(input logic [15:0] d);
    {dig1, dig2, dig3, dig4} = d;
  endtask

  // Reset for two edges, release, then check the blank prime cycle.
  task automatic restart(input logic [15:0] d);
    set_digs(d);
    clr = 1'b0;
    tick(); tick();
    chk("rst_an", {28'd0, an}, 32'hF);
    chk("rst_ca", {25'd0, ca}, 32'h7F);
    clr = 1'b1;
    tick();
    chk("prime_an", {28'd0, an}, 32'hF);
    chk("prime_ca", {25'd0, ca}, 32'h7F);
  endtask

  // Check `cycles` scan cycles starting at cycle 2; blank_m bit s blanks slot s.
  task automatic scan(input logic [15:0] d, input logic [3:0] blank_m, input int cycles, input string tag);
    for (int k = 0; k < cycles; k++) begin
      int s;
      logic [3:0] dg;
      tick();
      s  = (k / N) % 4;
      dg = d[15 - 4*s -: 4];
      chk({tag, "_an"}, {28'd0, an}, blank_m[s] ? 32'hF : {28'd0, an_tb[s]});
      chk({tag, "_ca"}, {25'd0, ca}, blank_m[s] ? 32'h7F : {25'd0, seg_tb[dg]});
    end
  endtask

  initial begin
    // Reset/prime: held in reset 3 cycles, then cycle 2 shows digit 1.
    set_digs(16'h1234);
    clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_an", {28'd0, an}, 32'hF);
      chk("hold_ca", {25'd0, ca}, 32'h7F);
    end
    clr = 1'b1;
    tick();
    chk("c1_an", {28'd0, an}, 32'hF);
    chk("c1_ca", {25'd0, ca}, 32'h7F);
    tick();
    chk("c2_an", {28'd0, an}, 32'b0111);
    chk("c2_ca", {25'd0, ca}, 32'b1111001);

    // Full scan with A,b,C,d over two frames.
    restart(16'hABCD);
    scan(16'hABCD, 4'b0000, 32, "scan");

    // Tear-free: dig2 changes 5->6 during the dig1 slot.
    restart(16'h1534);
    tick();
    chk("tear_d1_an", {28'd0, an}, 32'b0111);
    dig2 = 4'h6;
    tick(); tick(); tick();
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("tear_old_an", {28'd0, an}, 32'b1011);
      chk("tear_old_ca", {25'd0, ca}, 32'b0010010);
    end
    for (int k = 0; k < 12; k++) tick();
    chk("tear_nf_d1", {25'd0, ca}, {25'd0, seg_tb[1]});
    for (int k = 0; k < 4; k++) tick();
    chk("tear_new_an", {28'd0, an}, 32'b1011);
    chk("tear_new_ca", {25'd0, ca}, 32'b0000010);

    // Mid-frame reset during the dig3 slot.
    restart(16'h9876);
    scan(16'h9876, 4'b0000, 10, "pre");
    chk("mid_d3_an", {28'd0, an}, 32'b1101);
    clr = 1'b0;
    tick();
    chk("mid_rst_an", {28'd0, an}, 32'hF);
    chk("mid_rst_ca", {25'd0, ca}, 32'h7F);
    clr = 1'b1;
    tick();
    chk("mid_c1_an", {28'd0, an}, 32'hF);
    tick();
    chk("mid_c2_an", {28'd0, an}, 32'b0111);
    chk("mid_c2_ca", {25'd0, ca}, {25'd0, seg_tb[9]});

    // Leading zeros.
    restart(16'h0070);
`ifdef LEADING_ZERO_BLANK_EN
    scan(16'h0070, 4'b0011, 16, "lz0070");
`else
    scan(16'h0070, 4'b0000, 16, "lz0070");
`endif
    restart(16'h0000);
`ifdef LEADING_ZERO_BLANK_EN
    scan(16'h0000, 4'b0111, 16, "lz0000");
`else
    scan(16'h0000, 4'b0000, 16, "lz0000");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
